// File: rtl/ysyx_25060170_wbu.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | Module   : ysyx_25060170_wbu                                                     |
// | Write-back stage: 2-entry skid buffer, GPR file with bypassed read ports and a    |
// | retire counter. Define YSYX_WBU_TRACE_EN to add registered commit trace outputs.  |
// | Revision : 1.0  initial release                                                   |
// +----------------------------------------------------------------------------------+
module ysyx_25060170_wbu #(
   parameter int NR_REG = 32,
   parameter int XLEN   = 32,
   parameter int CNT_W  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [4:0]       in_rd_i,
   input  logic             in_wen_i,
   input  logic [XLEN-1:0]  in_data_i,
   input  logic             stall_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   output logic [XLEN-1:0]  rs1_data_o,
   output logic [XLEN-1:0]  rs2_data_o,
   output logic             hazard_o,
   output logic [CNT_W-1:0] instret_o
`ifdef YSYX_WBU_TRACE_EN
   ,
   output logic             commit_valid_o,
   output logic [4:0]       commit_rd_o,
   output logic [XLEN-1:0]  commit_data_o,
   output logic             commit_wen_o
`endif
);

   localparam int         IDX_W    = (NR_REG > 1) ? $clog2(NR_REG) : 1;
   localparam logic [5:0] NR_REG_L = 6'(NR_REG);

   logic [1:0]       count;
   logic [4:0]       buf_rd   [2];
   logic             buf_wen  [2];
   logic [XLEN-1:0]  buf_data [2];
   logic [XLEN-1:0]  gpr      [NR_REG];

   logic             push;
   logic             pop;
   logic             wr_slot;
   logic             head_live;
   logic             tail_live;
   logic             gpr_we;
   logic [IDX_W-1:0] gpr_idx;

   assign in_ready_o = (count != 2'd2);
   assign push       = in_valid_i & in_ready_o;
   assign pop        = (count != 2'd0) & ~stall_i;

   // The incoming entry lands right behind whatever survives this cycle's pop.
   assign wr_slot    = ~((count == 2'd0) | ((count == 2'd1) & pop));

   assign head_live  = (count != 2'd0) & ~pop;
   assign tail_live  = (count == 2'd2);

   assign gpr_we     = pop & buf_wen[0] & (buf_rd[0] != 5'd0) & ({1'b0, buf_rd[0]} < NR_REG_L);
   assign gpr_idx    = buf_rd[0][IDX_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            buf_rd[i]   <= '0;
            buf_wen[i]  <= 1'b0;
            buf_data[i] <= '0;
         end
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (pop) begin
            buf_rd[0]   <= buf_rd[1];
            buf_wen[0]  <= buf_wen[1];
            buf_data[0] <= buf_data[1];
         end
         if (push) begin
            buf_rd[wr_slot]   <= in_rd_i;
            buf_wen[wr_slot]  <= in_wen_i;
            buf_data[wr_slot] <= in_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR_REG; i++) begin
            gpr[i] <= '0;
         end
      end else if (gpr_we) begin
         gpr[gpr_idx] <= buf_data[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_o <= '0;
      end else if (pop) begin
         instret_o <= instret_o + CNT_W'(1);
      end
   end

   // A retiring head is forwarded so the IDU never sees the stale array value.
   always_comb begin
      rs1_data_o = '0;
      if (rs1_i != 5'd0 && {1'b0, rs1_i} < NR_REG_L) begin
         if (pop && buf_wen[0] && buf_rd[0] == rs1_i) begin
            rs1_data_o = buf_data[0];
         end else begin
            rs1_data_o = gpr[rs1_i[IDX_W-1:0]];
         end
      end
   end

   always_comb begin
      rs2_data_o = '0;
      if (rs2_i != 5'd0 && {1'b0, rs2_i} < NR_REG_L) begin
         if (pop && buf_wen[0] && buf_rd[0] == rs2_i) begin
            rs2_data_o = buf_data[0];
         end else begin
            rs2_data_o = gpr[rs2_i[IDX_W-1:0]];
         end
      end
   end

   always_comb begin
      hazard_o = 1'b0;
      if (head_live && buf_wen[0] && buf_rd[0] != 5'd0 &&
          (buf_rd[0] == rs1_i || buf_rd[0] == rs2_i)) begin
         hazard_o = 1'b1;
      end
      if (tail_live && buf_wen[1] && buf_rd[1] != 5'd0 &&
          (buf_rd[1] == rs1_i || buf_rd[1] == rs2_i)) begin
         hazard_o = 1'b1;
      end
   end

`ifdef YSYX_WBU_TRACE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_valid_o <= 1'b0;
         commit_rd_o    <= '0;
         commit_data_o  <= '0;
         commit_wen_o   <= 1'b0;
      end else begin
         commit_valid_o <= pop;
         if (pop) begin
            commit_rd_o   <= buf_rd[0];
            commit_data_o <= buf_data[0];
            commit_wen_o  <= buf_wen[0];
         end
      end
   end
`else
   // Trace disabled: no commit flops are built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_wbu.sv
`default_nettype none
// Testbench for ysyx_25060170_wbu: directed vector table, randomized reference-model
// check, async reset mid-operation, and counter wrap / RV32E bounds on a narrow instance.
module tb_ysyx_25060170_wbu;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        in_valid_i, in_ready_o, in_wen_i, stall_i, hazard_o;
   logic [4:0]  in_rd_i, rs1_i, rs2_i;
   logic [31:0] in_data_i, rs1_data_o, rs2_data_o;
   logic [63:0] instret_o;

   logic        s_valid, s_ready, s_wen, s_stall, s_haz;
   logic [4:0]  s_rd, s_rs1, s_rs2;
   logic [31:0] s_data, s_d1, s_d2;
   logic [2:0]  s_inst;

`ifdef YSYX_WBU_TRACE_EN
   logic        commit_valid_o, commit_wen_o, s_cv, s_cw;
   logic [4:0]  commit_rd_o, s_crd;
   logic [31:0] commit_data_o, s_cd;
`endif

   ysyx_25060170_wbu #(.NR_REG(32), .XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rd_i(in_rd_i),
      .in_wen_i(in_wen_i), .in_data_i(in_data_i), .stall_i(stall_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .hazard_o(hazard_o), .instret_o(instret_o)
`ifdef YSYX_WBU_TRACE_EN
      , .commit_valid_o(commit_valid_o), .commit_rd_o(commit_rd_o),
      .commit_data_o(commit_data_o), .commit_wen_o(commit_wen_o)
`endif
   );

   ysyx_25060170_wbu #(.NR_REG(16), .XLEN(32), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid_i(s_valid), .in_ready_o(s_ready), .in_rd_i(s_rd),
      .in_wen_i(s_wen), .in_data_i(s_data), .stall_i(s_stall),
      .rs1_i(s_rs1), .rs2_i(s_rs2), .rs1_data_o(s_d1), .rs2_data_o(s_d2),
      .hazard_o(s_haz), .instret_o(s_inst)
`ifdef YSYX_WBU_TRACE_EN
      , .commit_valid_o(s_cv), .commit_rd_o(s_crd),
      .commit_data_o(s_cd), .commit_wen_o(s_cw)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: queue of pending writes + register array
   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
   } ent_t;

   ent_t            m_q[$];
   logic [31:0]     m_gpr [32];
   longint unsigned m_instret;

   function automatic logic m_pop();
      return (m_q.size() != 0) && !stall_i;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_pop() && m_q[0].wen && m_q[0].rd == a) return m_q[0].data;
      return m_gpr[a];
   endfunction

   function automatic logic m_hazard();
      logic h;
      h = 1'b0;
      for (int i = 0; i < m_q.size(); i++) begin
         if (!(i == 0 && m_pop()) && m_q[i].wen && m_q[i].rd != 5'd0 &&
             (rs1_i == m_q[i].rd || rs2_i == m_q[i].rd))
            h = 1'b1;
      end
      return h;
   endfunction

   task automatic model_clock();
      ent_t e;
      logic pop, push;
      pop  = m_pop();
      push = in_valid_i && (m_q.size() < 2);
      if (pop) begin
         e = m_q.pop_front();
         if (e.wen && e.rd != 5'd0) m_gpr[e.rd] = e.data;
         m_instret++;
      end
      if (push) begin
         e.rd = in_rd_i; e.wen = in_wen_i; e.data = in_data_i;
         m_q.push_back(e);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_instret = 0;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic w, input logic [31:0] d,
                        input logic st, input logic [4:0] a1, input logic [4:0] a2);
      in_valid_i = v; in_rd_i = rd; in_wen_i = w; in_data_i = d;
      stall_i = st; rs1_i = a1; rs2_i = a2;
   endtask

   // ---------------- directed vector table
   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic        w;
      logic [31:0] d;
      logic        st;
      logic [4:0]  a1, a2;
      logic        rdy;
      logic [31:0] e1, e2;
      logic        hz;
      logic [63:0] inst;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic v, input logic [4:0] rd, input logic w, input logic [31:0] d,
                      input logic st, input logic [4:0] a1, input logic [4:0] a2,
                      input logic rdy, input logic [31:0] e1, input logic [31:0] e2,
                      input logic hz, input logic [63:0] inst);
      vec_t t;
      t.v = v; t.rd = rd; t.w = w; t.d = d; t.st = st; t.a1 = a1; t.a2 = a2;
      t.rdy = rdy; t.e1 = e1; t.e2 = e2; t.hz = hz; t.inst = inst;
      tv.push_back(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      s_valid = 0; s_rd = 0; s_wen = 0; s_data = 0; s_stall = 0; s_rs1 = 0; s_rs2 = 0;
      model_reset();

      //  v rd w data          st a1 a2  rdy rs1_data      rs2_data     hz inst
      add(0, 0, 0, 32'h0,        0, 5, 0,  1, 32'h0,        32'h0,       0, 0);
      add(1, 5, 1, 32'h1234,     0, 5, 0,  1, 32'h0,        32'h0,       0, 0);
      add(0, 0, 0, 32'h0,        0, 5, 0,  1, 32'h1234,     32'h0,       0, 0);
      add(0, 0, 0, 32'h0,        0, 5, 0,  1, 32'h1234,     32'h0,       0, 1);
      add(1, 0, 1, 32'hFFFFFFFF, 0, 0, 5,  1, 32'h0,        32'h1234,    0, 1);
      add(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,        32'h0,       0, 1);
      add(0, 0, 0, 32'h0,        0, 0, 5,  1, 32'h0,        32'h1234,    0, 2);
      add(1, 1, 1, 32'h11,       1, 1, 2,  1, 32'h0,        32'h0,       0, 2);
      add(1, 2, 1, 32'h22,       1, 1, 2,  1, 32'h0,        32'h0,       1, 2);
      add(1, 3, 1, 32'h33,       1, 1, 3,  0, 32'h0,        32'h0,       1, 2);
      add(1, 3, 1, 32'h33,       0, 1, 2,  0, 32'h11,       32'h0,       1, 2);
      add(1, 3, 1, 32'h33,       0, 2, 3,  1, 32'h22,       32'h0,       0, 3);
      add(0, 0, 0, 32'h0,        0, 3, 1,  1, 32'h33,       32'h11,      0, 4);
      add(0, 0, 0, 32'h0,        0, 2, 3,  1, 32'h22,       32'h33,      0, 5);
      add(1, 7, 1, 32'h77,       1, 0, 7,  1, 32'h0,        32'h0,       0, 5);
      add(0, 0, 0, 32'h0,        1, 0, 7,  1, 32'h0,        32'h0,       1, 5);
      add(0, 0, 0, 32'h0,        0, 7, 7,  1, 32'h77,       32'h77,      0, 5);
      add(1, 4, 0, 32'h44,       1, 4, 0,  1, 32'h0,        32'h0,       0, 6);
      add(0, 0, 0, 32'h0,        0, 4, 0,  1, 32'h0,        32'h0,       0, 6);
      add(0, 0, 0, 32'h0,        0, 4, 0,  1, 32'h0,        32'h0,       0, 7);
      add(1, 9, 1, 32'hA,        1, 0, 0,  1, 32'h0,        32'h0,       0, 7);
      add(1, 9, 1, 32'hB,        1, 9, 0,  1, 32'h0,        32'h0,       1, 7);
      add(0, 0, 0, 32'h0,        0, 9, 0,  0, 32'hA,        32'h0,       1, 7);
      add(0, 0, 0, 32'h0,        0, 9, 0,  1, 32'hB,        32'h0,       0, 8);
      add(0, 0, 0, 32'h0,        0, 9, 0,  1, 32'hB,        32'h0,       0, 9);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].v, tv[i].rd, tv[i].w, tv[i].d, tv[i].st, tv[i].a1, tv[i].a2);
         @(negedge clk);
         check($sformatf("vec%0d ready", i),   in_ready_o, tv[i].rdy);
         check($sformatf("vec%0d rs1", i),     rs1_data_o, tv[i].e1);
         check($sformatf("vec%0d rs2", i),     rs2_data_o, tv[i].e2);
         check($sformatf("vec%0d hazard", i),  hazard_o,   tv[i].hz);
         check($sformatf("vec%0d instret", i), instret_o,  tv[i].inst);
         model_clock();
         @(posedge clk);
         #1;
      end

      // ---------------- randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [4:0] rd, a1, a2;
         rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         drive($urandom_range(0, 9) < 7, rd, 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 9) < 3, a1, a2);
         @(negedge clk);
         check($sformatf("rnd%0d ready", n),   in_ready_o, m_q.size() < 2);
         check($sformatf("rnd%0d rs1", n),     rs1_data_o, m_read(rs1_i));
         check($sformatf("rnd%0d rs2", n),     rs2_data_o, m_read(rs2_i));
         check($sformatf("rnd%0d hazard", n),  hazard_o,   m_hazard());
         check($sformatf("rnd%0d instret", n), instret_o,  m_instret);
         model_clock();
         @(posedge clk);
         #1;
      end

      // ---------------- async reset with two buffered entries
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      drive(1, 12, 1, 32'h1212_1212, 0, 12, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 12, 0);
      @(posedge clk); #1;
      drive(1, 10, 1, 32'h00C0_FFEE, 1, 12, 10);
      @(negedge clk);
      check("gpr12 before reset", rs1_data_o, 32'h1212_1212);
      @(posedge clk); #1;
      drive(1, 11, 1, 32'h0000_BEEF, 1, 12, 10);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 12, 10);
      @(negedge clk);
      check("pre-reset hazard", hazard_o, 1);
      check("pre-reset ready", in_ready_o, 0);
      #1 rst = 1'b1;
      #1;
      check("async reset ready", in_ready_o, 1);
      check("async reset hazard", hazard_o, 0);
      check("async reset instret", instret_o, 0);
      check("async reset gpr12", rs1_data_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 10, 11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("discarded rd10", rs1_data_o, 0);
      check("discarded rd11", rs2_data_o, 0);
      check("discarded instret", instret_o, 0);
      check("post reset ready", in_ready_o, 1);

`ifdef YSYX_WBU_TRACE_EN
      // ---------------- commit trace pulse
      @(posedge clk); #1;
      drive(1, 3, 1, 32'hA5, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("trace idle before pop", commit_valid_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("trace valid", commit_valid_o, 1);
      check("trace rd", commit_rd_o, 3);
      check("trace data", commit_data_o, 32'hA5);
      check("trace wen", commit_wen_o, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("trace pulse ends", commit_valid_o, 0);
`endif

      // ---------------- narrow instance: 3-bit counter wrap, 16 registers
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1; s_wen = 1; s_rd = 0; s_data = 32'(i);
         if (i == 0) begin s_rd = 15; s_data = 32'h5A; end
         if (i == 1) begin s_rd = 20; s_data = 32'h77; end
         if (i == 2) begin s_rd = 14; s_data = 32'h99; s_wen = 0; end
         @(posedge clk); #1;
      end
      s_valid = 0; s_rs1 = 15; s_rs2 = 20;
      @(negedge clk);
      check("narrow instret before wrap", s_inst, 3'd7);
      @(posedge clk); #1;
      @(negedge clk);
      check("narrow instret wrap", s_inst, 3'd0);
      check("narrow rd15", s_d1, 32'h5A);
      check("narrow rs>=NR_REG", s_d2, 32'h0);
      check("narrow ready", s_ready, 1);
      check("narrow hazard", s_haz, 0);
      s_rs1 = 14; s_rs2 = 4;
      #1;
      check("narrow wen0 rd14", s_d1, 32'h0);
      check("narrow rd20 alias", s_d2, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
